// File: rtl/reg_pkg.sv
// rtl/reg_pkg.sv - register file shared types and sizing, including write-arbiter request records.
package reg_pkg;

    localparam int WORD_SIZE          = 32;
    localparam int NUM_PHYS_REGS      = 64;
    localparam int PHYS_IDX_W         = $clog2(NUM_PHYS_REGS);
    localparam int REG_WR_ARB_NUM_REQ = 4;

    typedef struct packed {
        logic                  en;
        logic [PHYS_IDX_W-1:0] index_in;
        logic [WORD_SIZE-1:0]  data_in;
    } RegFileWritePort;

    typedef struct packed {
        logic                  valid;
        logic [PHYS_IDX_W-1:0] index;
        logic [WORD_SIZE-1:0]  data;
    } RegWrReq;

endpackage

// File: rtl/rr_multi_pick.sv
// rtl/rr_multi_pick.sv - combinational rotating-priority picker granting up to NUM_PICK requests.
// A candidate whose conflict row overlaps an earlier grant is skipped and the scan continues.
module rr_multi_pick #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_PICK = 2,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]                req,
    input  logic [PTR_W-1:0]                  rr_ptr,
    input  logic [NUM_REQ-1:0][NUM_REQ-1:0]   conflict,
    output logic [NUM_REQ-1:0]                grant,
    output logic [NUM_PICK-1:0]               pick_vld,
    output logic [NUM_PICK-1:0][PTR_W-1:0]    pick_sel,
    output logic [PTR_W-1:0]                  next_ptr
);

    logic [PTR_W:0]   sum;
    logic [PTR_W:0]   nxt;
    logic [PTR_W-1:0] cand;
    int               cnt;

    always_comb begin
        grant    = '0;
        pick_vld = '0;
        pick_sel = '0;
        next_ptr = rr_ptr;
        sum      = '0;
        nxt      = '0;
        cand     = '0;
        cnt      = 0;
        for (int s = 0; s < NUM_REQ; s++) begin
            sum = {1'b0, rr_ptr} + (PTR_W+1)'(s);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            cand = sum[PTR_W-1:0];
            if (req[cand] && (cnt < NUM_PICK) && ((conflict[cand] & grant) == '0)) begin
                for (int k = 0; k < NUM_PICK; k++) begin
                    if (k == cnt) begin
                        pick_vld[k] = 1'b1;
                        pick_sel[k] = cand;
                    end
                end
                grant[cand] = 1'b1;
                cnt         = cnt + 1;
                nxt         = {1'b0, cand} + (PTR_W+1)'(1);
                if (nxt >= (PTR_W+1)'(NUM_REQ)) begin
                    nxt = '0;
                end
                next_ptr = nxt[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - buffers functional-unit results and round-robins them onto register-file write ports.
// Optional per-requester stall counters under REG_WR_ARB_STATS_EN.
module reg_write_arbiter
    import reg_pkg::*;
#(
    parameter int NUM_REQ         = REG_WR_ARB_NUM_REQ,
    parameter int NUM_WRITE_PORTS = 2,
    parameter int WORD_SIZE       = reg_pkg::WORD_SIZE,
    parameter int NUM_PHYS_REGS   = reg_pkg::NUM_PHYS_REGS,
    localparam int IDX_W          = $clog2(NUM_PHYS_REGS),
    localparam int PTR_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ-1:0][IDX_W-1:0]        req_index,
    input  logic [NUM_REQ-1:0][WORD_SIZE-1:0]    req_data,
    output RegFileWritePort [NUM_WRITE_PORTS-1:0] write_ports
`ifdef REG_WR_ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][15:0]             stall_cnt
`endif
);

    RegWrReq [NUM_REQ-1:0]                 buf_q, buf_d;
    logic [PTR_W-1:0]                      rr_ptr_q, rr_ptr_d;
    RegFileWritePort [NUM_WRITE_PORTS-1:0] wp_q, wp_d;

    logic [NUM_REQ-1:0]                    buf_valid;
    logic [NUM_REQ-1:0][NUM_REQ-1:0]       conflict;
    logic [NUM_REQ-1:0]                    grant;
    logic [NUM_WRITE_PORTS-1:0]            pick_vld;
    logic [NUM_WRITE_PORTS-1:0][PTR_W-1:0] pick_sel;
    logic [PTR_W-1:0]                      next_ptr;

    // Arbitration only sees buffered entries, so request-to-write is always two edges.
    always_comb begin
        buf_valid = '0;
        conflict  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            buf_valid[i] = buf_q[i].valid;
            for (int j = 0; j < NUM_REQ; j++) begin
                conflict[i][j] = (buf_q[i].index == buf_q[j].index);
            end
        end
    end

    rr_multi_pick #(
        .NUM_REQ  (NUM_REQ),
        .NUM_PICK (NUM_WRITE_PORTS)
    ) u_pick (
        .req      (buf_valid),
        .rr_ptr   (rr_ptr_q),
        .conflict (conflict),
        .grant    (grant),
        .pick_vld (pick_vld),
        .pick_sel (pick_sel),
        .next_ptr (next_ptr)
    );

    assign req_ready   = {NUM_REQ{~rst}} & (~buf_valid | grant);
    assign write_ports = wp_q;

    always_comb begin
        buf_d    = buf_q;
        rr_ptr_d = next_ptr;
        wp_d     = wp_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                buf_d[i].valid = 1'b0;
            end
            if (req_valid[i] && req_ready[i]) begin
                buf_d[i].valid = 1'b1;
                buf_d[i].index = req_index[i];
                buf_d[i].data  = req_data[i];
            end
        end
        // Idle ports drop en but keep their last index/data.
        for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
            wp_d[k].en = pick_vld[k];
            if (pick_vld[k]) begin
                wp_d[k].index_in = buf_q[pick_sel[k]].index;
                wp_d[k].data_in  = buf_q[pick_sel[k]].data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q    <= '0;
            rr_ptr_q <= '0;
            wp_q     <= '0;
        end else begin
            buf_q    <= buf_d;
            rr_ptr_q <= rr_ptr_d;
            wp_q     <= wp_d;
        end
    end

`ifdef REG_WR_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (buf_valid[i] && !grant[i] && (stall_q[i] != 16'hFFFF)) begin
                stall_d[i] = stall_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed vector table plus a full-contention scoreboard sequence.
module tb_reg_write_arbiter;
    import reg_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [3:0]             req_valid;
    logic [3:0]             req_ready;
    logic [3:0][5:0]        req_index;
    logic [3:0][31:0]       req_data;
    RegFileWritePort [1:0]  write_ports;
`ifdef REG_WR_ARB_STATS_EN
    logic [3:0][15:0]       stall_cnt;
`endif

    reg_write_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_index   (req_index),
        .req_data    (req_data),
        .write_ports (write_ports)
`ifdef REG_WR_ARB_STATS_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic [3:0]      valid;
        logic [3:0][5:0] idx;
        logic [3:0][31:0] data;
        logic [3:0]      exp_ready;
        RegFileWritePort exp_wp0;
        RegFileWritePort exp_wp1;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic RegFileWritePort wp(input logic en, input logic [5:0] idx, input logic [31:0] data);
        RegFileWritePort p;
        p.en       = en;
        p.index_in = idx;
        p.data_in  = data;
        return p;
    endfunction

    task automatic add(input logic r, input logic [3:0] v, input logic [3:0][5:0] idx,
                       input logic [3:0][31:0] data, input logic [3:0] rdy,
                       input RegFileWritePort w0, input RegFileWritePort w1);
        vec_t t;
        t.rst = r; t.valid = v; t.idx = idx; t.data = data;
        t.exp_ready = rdy; t.exp_wp0 = w0; t.exp_wp1 = w1;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    localparam logic [3:0][5:0]  I0 = '0;
    localparam logic [3:0][31:0] D0 = '0;
    localparam logic [3:0][5:0]  IQ = {6'd4, 6'd3, 6'd2, 6'd1};

    int               tcnt[4];
    int               last[4];
    int               maxgap[4];
    logic [31:0]      sb[4][$];

    initial begin
        rst = 1'b1; req_valid = '0; req_index = '0; req_data = '0;

        add(1, 4'b0000, I0, D0, 4'b0000, wp(0,0,0), wp(0,0,0));
        add(0, 4'b0001, {6'd0,6'd0,6'd0,6'd5}, {32'd0,32'd0,32'd0,32'hDEAD}, 4'b1111, wp(0,0,0), wp(0,0,0));
        add(0, 4'b0000, I0, D0, 4'b1111, wp(1,5,32'hDEAD), wp(0,0,0));
        add(0, 4'b0000, I0, D0, 4'b1111, wp(0,5,32'hDEAD), wp(0,0,0));
        add(1, 4'b0000, I0, D0, 4'b0000, wp(0,0,0), wp(0,0,0));
        add(0, 4'b1111, IQ, {32'hA0000003,32'hA0000002,32'hA0000001,32'hA0000000}, 4'b1111, wp(0,0,0), wp(0,0,0));
        add(0, 4'b1111, IQ, {32'hB0000003,32'hB0000002,32'hB0000001,32'hB0000000}, 4'b0011,
            wp(1,1,32'hA0000000), wp(1,2,32'hA0000001));
        add(0, 4'b1111, IQ, {32'hB0000003,32'hB0000002,32'hC0000001,32'hC0000000}, 4'b1100,
            wp(1,3,32'hA0000002), wp(1,4,32'hA0000003));
        add(0, 4'b1111, IQ, {32'hC0000003,32'hC0000002,32'hC0000001,32'hC0000000}, 4'b0011,
            wp(1,1,32'hB0000000), wp(1,2,32'hB0000001));
        add(0, 4'b1100, IQ, {32'hC0000003,32'hC0000002,32'd0,32'd0}, 4'b1100,
            wp(1,3,32'hB0000002), wp(1,4,32'hB0000003));
        add(0, 4'b0000, I0, D0, 4'b0011, wp(1,1,32'hC0000000), wp(1,2,32'hC0000001));
        add(0, 4'b0000, I0, D0, 4'b1111, wp(1,3,32'hC0000002), wp(1,4,32'hC0000003));
        add(0, 4'b0111, {6'd0,6'd7,6'd9,6'd9}, {32'd0,32'h77,32'hB,32'hA}, 4'b1111,
            wp(0,3,32'hC0000002), wp(0,4,32'hC0000003));
        add(0, 4'b0000, I0, D0, 4'b1101, wp(1,9,32'hA), wp(1,7,32'h77));
        add(0, 4'b0000, I0, D0, 4'b1111, wp(1,9,32'hB), wp(0,7,32'h77));
        add(0, 4'b0111, {6'd0,6'd12,6'd11,6'd10}, {32'd0,32'hD0000002,32'hD0000001,32'hD0000000}, 4'b1111,
            wp(0,9,32'hB), wp(0,7,32'h77));
        add(0, 4'b1000, {6'd13,6'd0,6'd0,6'd0}, {32'hD0000003,32'd0,32'd0,32'd0}, 4'b1101,
            wp(1,12,32'hD0000002), wp(1,10,32'hD0000000));
        add(0, 4'b0111, {6'd0,6'd22,6'd21,6'd20}, {32'd0,32'hE0000002,32'hE0000001,32'hE0000000}, 4'b1111,
            wp(1,11,32'hD0000001), wp(1,13,32'hD0000003));
        add(1, 4'b0000, I0, D0, 4'b0000, wp(0,0,0), wp(0,0,0));
        add(0, 4'b0000, I0, D0, 4'b1111, wp(0,0,0), wp(0,0,0));
        add(0, 4'b0000, I0, D0, 4'b1111, wp(0,0,0), wp(0,0,0));

        for (int n = 0; n < vecs.size(); n++) begin
            @(negedge clk);
            rst       = vecs[n].rst;
            req_valid = vecs[n].valid;
            req_index = vecs[n].idx;
            req_data  = vecs[n].data;
            #1;
            check($sformatf("v%0d_ready", n), 64'(req_ready), 64'(vecs[n].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_wp0", n), 64'(write_ports[0]), 64'(vecs[n].exp_wp0));
            check($sformatf("v%0d_wp1", n), 64'(write_ports[1]), 64'(vecs[n].exp_wp1));
        end

        // Full contention with fresh payloads after every accepted transfer.
        @(negedge clk);
        rst = 1'b1; req_valid = '0;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            tcnt[i] = 0; last[i] = 0; maxgap[i] = 0;
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            rst       = 1'b0;
            req_valid = 4'hF;
            for (int i = 0; i < 4; i++) begin
                req_index[i] = 6'(i + 1);
                req_data[i]  = {8'(8'hF0 + i), 24'(tcnt[i])};
            end
            #1;
            for (int i = 0; i < 4; i++) begin
                if (req_ready[i]) begin
                    sb[i].push_back(req_data[i]);
                    tcnt[i]++;
                end
            end
            @(posedge clk);
            #1;
            if (c > 0) begin
                check($sformatf("cont%0d_en", c), 64'(int'(write_ports[0].en) + int'(write_ports[1].en)), 64'd2);
                check($sformatf("cont%0d_order", c), 64'(write_ports[0].index_in), (c % 2 == 1) ? 64'd1 : 64'd3);
            end
            for (int k = 0; k < 2; k++) begin
                if (write_ports[k].en) begin
                    int r;
                    r = int'(write_ports[k].index_in) - 1;
                    if (r < 0 || r > 3 || sb[r].size() == 0) begin
                        check($sformatf("cont%0d_p%0d_src", c, k), 64'(write_ports[k].index_in), 64'hFFFF);
                    end else begin
                        check($sformatf("cont%0d_p%0d_data", c, k), 64'(write_ports[k].data_in), 64'(sb[r].pop_front()));
                        if (c - last[r] > maxgap[r]) maxgap[r] = c - last[r];
                        last[r] = c;
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (11 - last[i] > maxgap[i]) maxgap[i] = 11 - last[i];
            check($sformatf("cont_gap_r%0d", i), 64'(maxgap[i] <= 2), 64'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the physical register file's limited write ports among the functional-unit result buses (ALU, FPU, BRU, LSU, ...).
- Each requester has a valid/ready interface and a one-entry holding buffer.
- Each cycle, up to NUM_WRITE_PORTS buffered results are granted in rotating (round-robin) priority.
- Granted results are driven onto registered RegFileWritePort outputs that feed reg_file's write ports, which also set the scoreboard.

Parameters:
- NUM_REQ, 4, number of result-producing requesters.
- NUM_WRITE_PORTS, 2, register-file write ports driven per cycle.
- WORD_SIZE, reg_pkg::WORD_SIZE, data width.
- NUM_PHYS_REGS, reg_pkg::NUM_PHYS_REGS, physical register count; index width is $clog2(NUM_PHYS_REGS).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i presents a result.
- req_ready  out  NUM_REQ  requester i's result is accepted this cycle.
- req_index  in  NUM_REQ x $clog2(NUM_PHYS_REGS)  destination physical register.
- req_data  in  NUM_REQ x WORD_SIZE  result value.
- write_ports  out  NUM_WRITE_PORTS x RegFileWritePort  {en, index_in, data_in} to reg_file; registered.

Behaviour:
- Reset (rst=1 at posedge): all buffers empty, rr_ptr=0, all write_ports.en=0, index_in=0, data_in=0.
- req_ready is forced to 0 while rst=1.
- Buffer: buf_valid[i], buf_index[i], buf_data[i].
- Handshake: req_ready[i] = ~rst & (~buf_valid[i] | grant[i]), so a granted entry can be refilled in the same cycle.
- A transfer occurs when req_valid[i] & req_ready[i]; the buffer loads on that posedge.
- Once valid is asserted, the requester must hold valid and its payload stable until ready.
- Arbitration is combinational over buf_valid only; incoming req_valid never reaches the grant logic:
  - Scan requesters in order rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Grant the first NUM_WRITE_PORTS valid entries.
  - The k-th grant (in scan order) maps to write_ports[k].
- Same-index conflict: if a candidate's buf_index equals that of an entry already granted this cycle, skip it (it stays buffered) and continue scanning.
- Output register: on posedge, write_ports[k] <= {1, buf_index, buf_data} of the k-th grant. Unused ports get en=0; their index/data hold their previous values.
- Latency: req accepted at edge N -> earliest write_ports.en at edge N+1 -> reg_file write at edge N+2. Minimum request-to-write is 2 cycles.
- Throughput: NUM_WRITE_PORTS writes/cycle when that many are buffered.
- rr_ptr update: set to (index of last granted requester + 1) mod NUM_REQ; unchanged when nothing is granted.
  - Guarantees starvation-freedom: any buffered entry is granted within ceil(NUM_REQ/NUM_WRITE_PORTS) cycles, absent index conflicts.
- Simultaneous grant and refill of the same slot: the new request loads, and the old entry is emitted.
- Reset mid-operation: buffered results are discarded and in-flight write_ports.en clears at the same edge. Upstream must flush on reset.

Optional Feature:
- Macro: REG_WR_ARB_STATS_EN.
- When defined, adds output stall_cnt (NUM_REQ x 16).
  - Per-requester saturating counter.
  - Increments each cycle buf_valid[i] & ~grant[i].
  - Clears on rst.
  - Saturates at 16'hFFFF.
- When undefined, the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- reg_pkg gains:
  - typedef RegWrReq {valid, index, data};
  - localparam REG_WR_ARB_NUM_REQ = 4.
- RegFileWritePort is reused unchanged.
- One sub-module: rr_multi_pick.
  - Combinational rotating-priority picker.
  - Inputs: NUM_REQ-bit request vector, rr_ptr.
  - Outputs: up to NUM_WRITE_PORTS one-hot/encoded grants.
  - Takes an index-conflict mask input.

Test Plan:
- Single write: after reset, req0 valid, idx=5, data=32'hDEAD -> req_ready[0]=1. Next cycle write_ports[0]={1,5,DEAD}; write_ports[1].en=0.
- Full contention: reqs 0-3 valid every cycle, distinct idx, rr_ptr=0.
  - Cycle 1 grants {0,1}, cycle 2 grants {2,3}, cycle 3 grants {0,1}.
  - Exactly 2 en per cycle.
  - No requester waits more than 2 cycles.
- Backpressure: hold req0 and req1 valid while the buffers are full and ungranted -> req_ready=0 and the payload is retained. When granted, the same-cycle refill is accepted.
- Index conflict: req0 and req1 both target idx=9 (0xA and 0xB) -> req0 written first, req1 the following cycle. Never two en with index 9 in one cycle.
- Reset mid-stream: assert rst with 3 buffers full -> next edge all en=0, req_ready=0 during reset. After release, no stale writes appear.
- Stats (REG_WR_ARB_STATS_EN): 4 always-valid requesters for 10 cycles -> each stall_cnt ≈ 5. Force saturation -> holds at FFFF.
